// File: rtl/dt_pkg.sv
// Shared constants and FSM state type for the DT binary-image (sti) loader.
package dt_pkg;

  localparam int unsigned IMG_W  = 128;
  localparam int unsigned IMG_H  = 128;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned NPIX   = IMG_W * IMG_H;
  localparam int unsigned NWORD  = NPIX / WORD_W;
  localparam int unsigned AW     = $clog2(NWORD);
  localparam int unsigned PW     = $clog2(NPIX);
  localparam int unsigned BW     = $clog2(WORD_W);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READY
  } dt_state_e;

endpackage

// File: rtl/dt_sti_ram.sv
// NWORD x WORD_W sti image store: synchronous write, asynchronous read.
module dt_sti_ram
  import dt_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem [NWORD];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/dt_sti_loader.sv
// Serial 1-bit pixel stream -> 16-pixel MSB-first words in the sti store,
// with frame-complete flag, pix_last consistency check and DT read port.
module dt_sti_loader
  import dt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pix_valid,
  input  logic              pix_data,
  input  logic              pix_last,
  output logic              pix_ready,
  output logic              load_done,
  output logic              load_err,
  input  logic              sti_rd,
  input  logic [AW-1:0]     sti_addr,
  output logic [WORD_W-1:0] sti_di
);

  dt_state_e         state_q, state_d;
  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic [WORD_W-2:0] shreg_q, shreg_d;
  logic              err_q, err_d;
  logic              xfer;
  logic              frame_end;
  logic              we;
  logic [WORD_W-1:0] rd_data;

  assign pix_ready = (state_q == LOAD);
  assign load_done = (state_q == READY);
  assign load_err  = err_q;
  assign xfer      = pix_valid && (state_q == LOAD);
  assign frame_end = (pcnt_q == PW'(NPIX - 1));

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    shreg_d = shreg_q;
    err_d   = err_q;
    we      = 1'b0;
    // start overrides a coincident pixel accept, including the final one
    if (start) begin
      state_d = LOAD;
      pcnt_d  = '0;
      shreg_d = '0;
      err_d   = 1'b0;
    end else if (xfer) begin
      shreg_d = {shreg_q[WORD_W-3:0], pix_data};
      pcnt_d  = pcnt_q + PW'(1);
      we      = &pcnt_q[BW-1:0];
      if (pix_last != frame_end) begin
        err_d = 1'b1;
      end
      if (frame_end) begin
        state_d = READY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      shreg_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      shreg_q <= shreg_d;
      err_q   <= err_d;
    end
  end

  dt_sti_ram u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (pcnt_q[PW-1:BW]),
    .wdata_i ({shreg_q, pix_data}),
    .raddr_i (sti_addr),
    .rdata_o (rd_data)
  );

  assign sti_di = (load_done && sti_rd) ? rd_data : '0;

endmodule

// File: tb/tb_dt_sti_loader.sv
module tb_dt_sti_loader;
  import dt_pkg::*;

  logic              clk = 1'b0;
  logic              reset, start, pix_valid, pix_data, pix_last, sti_rd;
  logic              pix_ready, load_done, load_err;
  logic [AW-1:0]     sti_addr;
  logic [WORD_W-1:0] sti_di;

  always #5 clk = ~clk;

  dt_sti_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_last  (pix_last),
    .pix_ready (pix_ready),
    .load_done (load_done),
    .load_err  (load_err),
    .sti_rd    (sti_rd),
    .sti_addr  (sti_addr),
    .sti_di    (sti_di)
  );

  typedef enum {K_DI, K_DONE, K_ERR, K_RDY} kind_e;
  typedef struct {
    kind_e       kind;
    logic [15:0] exp;
    int          info;
  } chk_t;

  chk_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  bit          frame[NPIX];
  logic [15:0] model_mem[NWORD];
  bit          model_done = 0;
  bit          model_err  = 0;

  function automatic string kname(kind_e k);
    case (k)
      K_DI:    return "sti_di";
      K_DONE:  return "load_done";
      K_ERR:   return "load_err";
      default: return "pix_ready";
    endcase
  endfunction

  function automatic logic [15:0] exp_di();
    return (model_done && sti_rd) ? model_mem[sti_addr] : 16'h0000;
  endfunction

  task automatic commit_frame();
    for (int unsigned y = 0; y < IMG_H; y++)
      for (int unsigned x = 0; x < IMG_W; x++)
        model_mem[y * (IMG_W / 16) + x / 16][15 - (x % 16)] = frame[y * IMG_W + x];
  endtask

  task automatic push_chk(kind_e k, logic [15:0] e, int info);
    exp_q.push_back('{kind: k, exp: e, info: info});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        chk_t        c;
        logic [15:0] act;
        c = exp_q.pop_front();
        case (c.kind)
          K_DI:    act = sti_di;
          K_DONE:  act = {15'b0, load_done};
          K_ERR:   act = {15'b0, load_err};
          default: act = {15'b0, pix_ready};
        endcase
        total++;
        if (act == c.exp) passed++;
        else $display("FAIL %s (info %0d): got %h expected %h", kname(c.kind), c.info, act, c.exp);
      end
    end
  end

  task automatic check_read(int unsigned a, bit rd);
    sti_rd   = rd;
    sti_addr = AW'(a);
    push_chk(K_DI, exp_di(), int'(a));
    cyc();
  endtask

  task automatic check_status(int info);
    push_chk(K_DONE, {15'b0, model_done}, info);
    push_chk(K_ERR,  {15'b0, model_err},  info);
    cyc();
  endtask

  task automatic do_start();
    start = 1'b1;
    push_chk(K_DI,   exp_di(), 900);
    push_chk(K_DONE, {15'b0, model_done}, 900);
    cyc();
    start      = 1'b0;
    model_done = 0;
    model_err  = 0;
    push_chk(K_DI,   exp_di(), 901);
    push_chk(K_DONE, 16'h0000, 901);
    push_chk(K_ERR,  16'h0000, 901);
    push_chk(K_RDY,  16'h0001, 901);
    cyc();
  endtask

  task automatic feed(int unsigned n, int unsigned gap_mod, int last_at, bit coincide, bit rd_during);
    for (int unsigned i = 0; i < n; i++) begin
      if (gap_mod > 0) begin
        while ($urandom_range(gap_mod - 1) == 0) begin
          pix_valid = 1'b0;
          cyc();
        end
      end
      pix_valid = 1'b1;
      pix_data  = frame[i];
      pix_last  = ((last_at >= 0) && (i == int'(unsigned'(last_at)))) || (i == NPIX - 1);
      if (i == 0) push_chk(K_RDY, 16'h0001, 1000);
      if ((last_at >= 0) && ((i == unsigned'(last_at)) || (i == unsigned'(last_at) + 1)))
        push_chk(K_ERR, {15'b0, model_err}, int'(i));
      if (rd_during && (i % 1024 == 0)) begin
        sti_rd   = 1'b1;
        sti_addr = AW'($urandom_range(NWORD - 1));
        push_chk(K_DI, exp_di(), int'(i));
      end
      if (i == NPIX - 1) begin
        push_chk(K_DONE, {15'b0, model_done}, int'(i));
        if (coincide) start = 1'b1;
      end
      cyc();
      if (pix_last != (i == NPIX - 1)) model_err = 1;
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    start     = 1'b0;
    if (n == NPIX) begin
      if (coincide) begin
        model_done = 0;
        model_err  = 0;
      end else begin
        commit_frame();
        model_done = 1;
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = 1'b0;
    pix_last = 1'b0; sti_rd = 1'b0; sti_addr = '0;
    cyc(); cyc(); cyc();
    reset = 1'b0;
    push_chk(K_RDY, 16'h0000, 0);
    check_status(0);
    check_read(0, 1);

    for (int unsigned i = 0; i < NPIX; i++) frame[i] = 1'($urandom);
    do_start();
    feed(5000, 0, -1, 0, 0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    model_done = 0;
    model_err  = 0;
    total++;
    if ((pix_ready == 1'b0) && (load_done == 1'b0)) passed++;
    else $display("FAIL direct: after reset pix_ready=%b load_done=%b", pix_ready, load_done);
    push_chk(K_RDY, 16'h0000, 5000);
    check_status(5000);
    check_read(0, 1);

    for (int unsigned i = 0; i < NPIX; i++) frame[i] = ~i[0];
    do_start();
    feed(NPIX, 0, -1, 0, 0);
    check_status(1);
    sti_rd = 1'b1; sti_addr = '0;
    #1;
    total++;
    if (sti_di == 16'hAAAA) passed++;
    else $display("FAIL direct: sti_di@0 got %h expected aaaa", sti_di);
    sti_addr = AW'(NWORD - 1);
    #1;
    total++;
    if (sti_di == 16'hAAAA) passed++;
    else $display("FAIL direct: sti_di@1023 got %h expected aaaa", sti_di);
    sti_rd = 1'b0;
    #1;
    total++;
    if (sti_di == 16'h0000) passed++;
    else $display("FAIL direct: sti_di with sti_rd=0 got %h expected 0000", sti_di);
    cyc();
    push_chk(K_DI, 16'hAAAA, 2);
    check_read(0, 1);
    push_chk(K_DI, 16'hAAAA, 3);
    check_read(NWORD - 1, 1);
    for (int unsigned a = 0; a < NWORD; a++) check_read(a, 1);
    check_read(5, 0);

    for (int unsigned i = 0; i < NPIX; i++) frame[i] = 1'($urandom);
    sti_rd = 1'b1; sti_addr = '0;
    do_start();
    feed(NPIX, 0, 100, 0, 1);
    check_status(2);
    for (int unsigned k = 0; k < 64; k++) check_read($urandom_range(NWORD - 1), 1);

    for (int unsigned i = 0; i < NPIX; i++) frame[i] = 1'($urandom);
    do_start();
    feed(NPIX, 0, -1, 1, 0);
    total++;
    if ((load_done == 1'b0) && (pix_ready == 1'b1)) passed++;
    else $display("FAIL direct: coincident start load_done=%b pix_ready=%b", load_done, pix_ready);
    push_chk(K_RDY, 16'h0001, 3);
    check_status(3);
    check_read(0, 1);

    for (int unsigned i = 0; i < NPIX; i++) frame[i] = (i == 17);
    feed(NPIX, 16, -1, 0, 0);
    check_status(4);
    sti_rd = 1'b1; sti_addr = AW'(1);
    #1;
    total++;
    if (sti_di == 16'h4000) passed++;
    else $display("FAIL direct: sti_di@1 got %h expected 4000", sti_di);
    cyc();
    push_chk(K_DI, 16'h4000, 4);
    check_read(1, 1);
    for (int unsigned a = 0; a < NWORD; a++) check_read(a, 1);
    check_read(1, 0);

    cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
